// File: rtl/axi4_req_sched.sv
// Request scheduler: buffers polled host read/write requests in a FIFO and
// dispatches them one at a time, in order, to separate read and write engines.
module axi4_req_sched #(
  parameter int ADRW  = 64,
  parameter int DEPTH = 4,
  parameter int TMO   = 1024
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            req_valid,
  input  logic            req_is_wr,
  input  logic [ADRW-1:0] req_addr,
  input  logic [7:0]      req_len,
  output logic            o_rd_valid,
  input  logic            i_rd_ready,
  output logic [ADRW-1:0] o_rd_addr,
  output logic [7:0]      o_rd_len,
  input  logic            i_rd_done,
  output logic            o_wr_valid,
  input  logic            i_wr_ready,
  output logic [ADRW-1:0] o_wr_addr,
  output logic [7:0]      o_wr_len,
  input  logic            i_wr_done,
  output logic [$clog2(DEPTH):0] o_count,
  output logic            o_full,
  output logic            o_busy,
  output logic            o_drop,
  output logic            o_timeout,
  input  logic            i_clr_err,
  output logic [15:0]     o_rd_cnt,
  output logic [15:0]     o_wr_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 1 + ADRW + 8;
  localparam int TW = $clog2(TMO + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE_RD,
    S_ISSUE_WR,
    S_WAIT_RD,
    S_WAIT_WR
  } state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic [EW-1:0]   r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [TW-1:0]   r_timer;

  logic            r_rd_valid;
  logic [ADRW-1:0] r_rd_addr;
  logic [7:0]      r_rd_len;
  logic            r_wr_valid;
  logic [ADRW-1:0] r_wr_addr;
  logic [7:0]      r_wr_len;
  logic [15:0]     r_rd_cnt;
  logic [15:0]     r_wr_cnt;
  logic            r_drop;
  logic            r_timeout;

  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic [EW-1:0]   w_head;
  logic            w_head_wr;
  logic [ADRW-1:0] w_head_addr;
  logic [7:0]      w_head_len;
  logic            w_rd_fin;
  logic            w_wr_fin;
  logic            w_waiting;
  logic            w_tmo_hit;
  logic            w_tmo_set;
  logic            w_drop_set;

  assign w_full      = (r_count == CW'(DEPTH));
  assign w_push      = req_valid && !w_full;
  assign w_pop       = (r_state == S_IDLE) && (r_count != '0);
  // Head is read combinationally so a pop loads the engine outputs in the same edge.
  assign w_head      = r_mem[r_rd_ptr];
  assign w_head_wr   = w_head[EW-1];
  assign w_head_addr = w_head[EW-2:8];
  assign w_head_len  = w_head[7:0];

  assign w_rd_fin    = (r_state == S_WAIT_RD) && i_rd_done;
  assign w_wr_fin    = (r_state == S_WAIT_WR) && i_wr_done;
  assign w_waiting   = (r_state == S_WAIT_RD) || (r_state == S_WAIT_WR);
  assign w_tmo_hit   = (r_timer == TW'(TMO - 1));
  assign w_tmo_set   = w_waiting && w_tmo_hit && !w_rd_fin && !w_wr_fin;
  assign w_drop_set  = req_valid && w_full;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {req_is_wr, req_addr, req_len};
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:     if (w_pop) w_state_next = w_head_wr ? S_ISSUE_WR : S_ISSUE_RD;
      S_ISSUE_RD: if (i_rd_ready) w_state_next = S_WAIT_RD;
      S_ISSUE_WR: if (i_wr_ready) w_state_next = S_WAIT_WR;
      S_WAIT_RD:  if (i_rd_done || w_tmo_hit) w_state_next = S_IDLE;
      S_WAIT_WR:  if (i_wr_done || w_tmo_hit) w_state_next = S_IDLE;
      default:    w_state_next = S_IDLE;
    endcase
  end

  // Timer runs only while staying in a WAIT state, so it is zero on every entry.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_timer <= '0;
    else if (w_waiting && (w_state_next == r_state)) r_timer <= r_timer + 1'b1;
    else r_timer <= '0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_valid <= 1'b0;
      r_rd_addr  <= '0;
      r_rd_len   <= '0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_len   <= '0;
    end else begin
      if (w_pop && !w_head_wr) begin
        r_rd_valid <= 1'b1;
        r_rd_addr  <= w_head_addr;
        r_rd_len   <= w_head_len;
      end else if ((r_state == S_ISSUE_RD) && i_rd_ready) begin
        r_rd_valid <= 1'b0;
      end
      if (w_pop && w_head_wr) begin
        r_wr_valid <= 1'b1;
        r_wr_addr  <= w_head_addr;
        r_wr_len   <= w_head_len;
      end else if ((r_state == S_ISSUE_WR) && i_wr_ready) begin
        r_wr_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_cnt  <= '0;
      r_wr_cnt  <= '0;
      r_drop    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (w_rd_fin) r_rd_cnt <= r_rd_cnt + 16'd1;
      if (w_wr_fin) r_wr_cnt <= r_wr_cnt + 16'd1;
      // A new error event in the same cycle as the clear keeps the flag set.
      if (w_drop_set)     r_drop <= 1'b1;
      else if (i_clr_err) r_drop <= 1'b0;
      if (w_tmo_set)      r_timeout <= 1'b1;
      else if (i_clr_err) r_timeout <= 1'b0;
    end
  end

  assign o_rd_valid = r_rd_valid;
  assign o_rd_addr  = r_rd_addr;
  assign o_rd_len   = r_rd_len;
  assign o_wr_valid = r_wr_valid;
  assign o_wr_addr  = r_wr_addr;
  assign o_wr_len   = r_wr_len;
  assign o_count    = r_count;
  assign o_full     = w_full;
  assign o_busy     = (r_state != S_IDLE);
  assign o_drop     = r_drop;
  assign o_timeout  = r_timeout;
  assign o_rd_cnt   = r_rd_cnt;
  assign o_wr_cnt   = r_wr_cnt;

endmodule

// File: tb/tb_axi4_req_sched.sv
// Directed bench for axi4_req_sched: a scoreboard queue holds the commands each
// accepted request should produce; a negedge monitor checks every engine handshake.
module tb_axi4_req_sched;

  localparam int ADRW  = 64;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic            req_valid;
  logic            req_is_wr;
  logic [ADRW-1:0] req_addr;
  logic [7:0]      req_len;
  logic            o_rd_valid;
  logic            i_rd_ready;
  logic [ADRW-1:0] o_rd_addr;
  logic [7:0]      o_rd_len;
  logic            i_rd_done;
  logic            o_wr_valid;
  logic            i_wr_ready;
  logic [ADRW-1:0] o_wr_addr;
  logic [7:0]      o_wr_len;
  logic            i_wr_done;
  logic [$clog2(DEPTH):0] o_count;
  logic            o_full;
  logic            o_busy;
  logic            o_drop;
  logic            o_timeout;
  logic            i_clr_err;
  logic [15:0]     o_rd_cnt;
  logic [15:0]     o_wr_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  logic [72:0] sb_q[$];

  axi4_req_sched #(.ADRW(ADRW), .DEPTH(DEPTH), .TMO(TMO)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .req_valid(req_valid), .req_is_wr(req_is_wr), .req_addr(req_addr), .req_len(req_len),
    .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready), .o_rd_addr(o_rd_addr),
    .o_rd_len(o_rd_len), .i_rd_done(i_rd_done),
    .o_wr_valid(o_wr_valid), .i_wr_ready(i_wr_ready), .o_wr_addr(o_wr_addr),
    .o_wr_len(o_wr_len), .i_wr_done(i_wr_done),
    .o_count(o_count), .o_full(o_full), .o_busy(o_busy), .o_drop(o_drop),
    .o_timeout(o_timeout), .i_clr_err(i_clr_err),
    .o_rd_cnt(o_rd_cnt), .o_wr_cnt(o_wr_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_cmd(input logic is_wr, input logic [63:0] addr, input logic [7:0] len);
    logic [72:0] obs_e;
    logic [72:0] exp_e;
    obs_e = {is_wr, addr, len};
    n_tests++;
    assert (sb_q.size() != 0) else begin
      n_fail++;
      $error("FAIL cmd_unexpected: observed=%0h expected=none", obs_e);
    end
    if (sb_q.size() != 0) begin
      exp_e = sb_q.pop_front();
      $display("[TB] cmd %s addr=%0h len=%0d", is_wr ? "wr" : "rd", addr, len);
      assert (obs_e === exp_e) else begin
        n_fail++;
        $error("FAIL cmd_order: observed=%0h expected=%0h", obs_e, exp_e);
      end
    end
  endtask

  // Inputs change 1 time unit after posedge, so they are stable here.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_rd_valid || o_wr_valid) begin
        n_tests++;
        assert (!(o_rd_valid && o_wr_valid)) else begin
          n_fail++;
          $error("FAIL both_valid: observed=1 expected=0");
        end
      end
      if (o_rd_valid && i_rd_ready) check_cmd(1'b0, o_rd_addr, o_rd_len);
      if (o_wr_valid && i_wr_ready) check_cmd(1'b1, o_wr_addr, o_wr_len);
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic is_wr, input logic [63:0] addr, input logic [7:0] len,
                      input bit expect_accept);
    req_valid = 1'b1;
    req_is_wr = is_wr;
    req_addr  = addr;
    req_len   = len;
    if (expect_accept) sb_q.push_back({is_wr, addr, len});
    step();
  endtask

  task automatic do_reset();
    i_rst      = 1'b1;
    req_valid  = 1'b0;
    req_is_wr  = 1'b0;
    req_addr   = '0;
    req_len    = '0;
    i_rd_ready = 1'b0;
    i_rd_done  = 1'b0;
    i_wr_ready = 1'b0;
    i_wr_done  = 1'b0;
    i_clr_err  = 1'b0;
    sb_q.delete();
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    i_rst = 1'b1;
    do_reset();
    chk("rst_count", 64'(o_count), 0);
    chk("rst_busy", 64'(o_busy), 0);
    chk("rst_valids", 64'({o_rd_valid, o_wr_valid}), 0);
    chk("rst_flags", 64'({o_full, o_drop, o_timeout}), 0);
    chk("rst_cnts", 64'({o_rd_cnt, o_wr_cnt}), 0);

    // Single read; foreign done in WAIT_RD is ignored
    i_rd_ready = 1'b1;
    send(1'b0, 64'h1000, 8'd3, 1'b1);
    req_valid = 1'b0;
    chk("rd1_not_yet", 64'(o_rd_valid), 0);
    step();
    chk("rd1_valid", 64'(o_rd_valid), 1);
    chk("rd1_addr", o_rd_addr, 64'h1000);
    chk("rd1_len", 64'(o_rd_len), 3);
    chk("rd1_busy", 64'(o_busy), 1);
    step();
    chk("rd1_valid_drop", 64'(o_rd_valid), 0);
    i_wr_done = 1'b1;
    step();
    i_wr_done = 1'b0;
    chk("rd1_ign_wrdone_busy", 64'(o_busy), 1);
    chk("rd1_ign_wrdone_cnt", 64'(o_wr_cnt), 0);
    repeat (3) step();
    i_rd_done = 1'b1;
    step();
    i_rd_done = 1'b0;
    chk("rd1_cnt", 64'(o_rd_cnt), 1);
    chk("rd1_idle", 64'(o_busy), 0);
    chk("rd1_sb_empty", 64'(sb_q.size()), 0);

    // Ordering: wr A, rd B, wr C back to back
    do_reset();
    i_rd_ready = 1'b1;
    i_wr_ready = 1'b1;
    i_rd_done  = 1'b1;
    i_wr_done  = 1'b1;
    send(1'b1, 64'h2000, 8'd1, 1'b1);
    send(1'b0, 64'h3000, 8'd2, 1'b1);
    send(1'b1, 64'h4000, 8'd0, 1'b1);
    req_valid = 1'b0;
    repeat (14) step();
    chk("ord_wr_cnt", 64'(o_wr_cnt), 2);
    chk("ord_rd_cnt", 64'(o_rd_cnt), 1);
    chk("ord_idle", 64'(o_busy), 0);
    chk("ord_sb_empty", 64'(sb_q.size()), 0);

    // Overflow: six writes into a stalled write engine
    do_reset();
    for (int i = 0; i < 6; i++) begin
      send(1'b1, 64'h5000 + 64'(i) * 64'h100, 8'(i), i < 5);
    end
    req_valid = 1'b0;
    chk("ovf_count", 64'(o_count), 4);
    chk("ovf_full", 64'(o_full), 1);
    chk("ovf_drop", 64'(o_drop), 1);
    chk("ovf_wr_addr", o_wr_addr, 64'h5000);
    send(1'b1, 64'h9999, 8'd9, 1'b0);
    i_clr_err = 1'b1;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    i_clr_err = 1'b0;
    chk("ovf_set_wins", 64'(o_drop), 1);
    chk("ovf_count_hold", 64'(o_count), 4);
    i_clr_err = 1'b1;
    step();
    i_clr_err = 1'b0;
    chk("ovf_clr", 64'(o_drop), 0);
    i_wr_ready = 1'b1;
    i_wr_done  = 1'b1;
    repeat (20) step();
    chk("ovf_wr_cnt", 64'(o_wr_cnt), 5);
    chk("ovf_empty", 64'({o_count, o_full}), 0);
    chk("ovf_sb_empty", 64'(sb_q.size()), 0);

    // Timeout: read accepted, done never arrives
    do_reset();
    i_rd_ready = 1'b1;
    send(1'b0, 64'h6000, 8'd7, 1'b1);
    req_valid = 1'b0;
    step();
    step();
    chk("tmo_wait_busy", 64'(o_busy), 1);
    repeat (15) step();
    chk("tmo_not_yet", 64'(o_timeout), 0);
    chk("tmo_still_busy", 64'(o_busy), 1);
    step();
    chk("tmo_flag", 64'(o_timeout), 1);
    chk("tmo_idle", 64'(o_busy), 0);
    chk("tmo_rd_cnt", 64'(o_rd_cnt), 0);
    i_clr_err = 1'b1;
    step();
    i_clr_err = 1'b0;
    chk("tmo_clr", 64'(o_timeout), 0);

    // Reset while a write is being issued with three more queued
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 64'h7000 + 64'(i), 8'(i), 1'b1);
    end
    req_valid = 1'b0;
    chk("mid_wr_valid", 64'(o_wr_valid), 1);
    chk("mid_count", 64'(o_count), 3);
    #2 i_rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'({o_rd_valid, o_wr_valid}), 0);
    chk("mid_rst_wr_cmd", 64'(o_wr_addr) | 64'(o_wr_len), 0);
    chk("mid_rst_count", 64'({o_count, o_full, o_busy}), 0);
    sb_q.delete();
    step();
    i_rst = 1'b0;
    i_wr_ready = 1'b1;
    i_wr_done  = 1'b1;
    repeat (5) step();
    chk("mid_no_completion", 64'(o_wr_cnt), 0);
    chk("mid_stays_idle", 64'({o_wr_valid, o_busy}), 0);

    // Counter wrap: preload near the top, then complete three reads
    do_reset();
    force dut.r_rd_cnt = 16'hFFFD;
    step();
    release dut.r_rd_cnt;
    chk("wrap_preload", 64'(o_rd_cnt), 64'hFFFD);
    i_rd_ready = 1'b1;
    i_rd_done  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(1'b0, 64'h8000 + 64'(i) * 64'h4, 8'd0, 1'b1);
    end
    req_valid = 1'b0;
    repeat (12) step();
    chk("wrap_rd_cnt", 64'(o_rd_cnt), 0);
    chk("wrap_sb_empty", 64'(sb_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
